// File: rtl/ram_burst_master_pkg.sv
// Shared types and defaults for the RAM burst master: FSM state encoding and
// the default geometry of the 64x8 single-port RAM it drives.
package ram_burst_master_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 6;
    localparam int LW_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Host command/read-return signals plus the RAM port of the burst master.
// The master modport is the initiator (RTL) view; slave is the host/RAM view.
interface ram_burst_master_if
    import ram_burst_master_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;

    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          done;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, ram_q,
        output cmd_ready, rd_valid, rd_data, rd_last, done,
        output ram_we, ram_addr, ram_data
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len, ram_q,
        input  cmd_ready, rd_valid, rd_data, rd_last, done,
        input  ram_we, ram_addr, ram_data
    );

endinterface

// File: rtl/ram_burst_master.sv
// Turns one host command at a time into back-to-back single-cycle accesses on
// a single-port RAM: single/burst reads and single/fill writes, 1 beat/cycle.
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    ram_burst_master_if.master bus
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   wbyte;
    logic [LW-1:0]   beats_left;
    logic            cmd_ready_r;
    logic            rd_vld_p1;
    logic            rd_last_p1;
    logic            done_p1;
    logic            accept;
    logic            busy;
    logic            last_beat;

    assign accept    = bus.cmd_valid && bus.cmd_ready;
    assign busy      = (state == ST_WR) || (state == ST_RD);
    assign last_beat = busy && (beats_left == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = bus.cmd_we ? ST_WR : ST_RD;
            ST_WR,
            ST_RD:   if (beats_left == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            rd_vld_p1   <= 1'b0;
            rd_last_p1  <= 1'b0;
            done_p1     <= 1'b0;
            cur_addr    <= '0;
            wbyte       <= '0;
            beats_left  <= '0;
        end else begin
            state       <= state_nxt;
            cmd_ready_r <= (state_nxt == ST_IDLE);
            // Read return lags the address beat by one cycle to match RAM latency.
            rd_vld_p1   <= (state == ST_RD);
            rd_last_p1  <= (state == ST_RD) && (beats_left == '0);
            done_p1     <= last_beat;
            if (accept) begin
                cur_addr   <= bus.cmd_addr;
                wbyte      <= bus.cmd_wdata;
                beats_left <= bus.cmd_len;
            end else if (busy) begin
                // Address wraps modulo 2^AW by natural overflow.
                cur_addr   <= cur_addr + ADDR_ONE;
                beats_left <= beats_left - LEN_ONE;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_r && !rst;
    assign bus.ram_we    = (state == ST_WR);
    assign bus.ram_addr  = cur_addr;
    assign bus.ram_data  = wbyte;
    assign bus.rd_valid  = rd_vld_p1;
    assign bus.rd_data   = rd_vld_p1 ? bus.ram_q : '0;
    assign bus.rd_last   = rd_last_p1;
    assign bus.done      = done_p1;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 64x8 single-port RAM
// (write on we, registered read address otherwise) as the responder.
module tb_ram_burst_master;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    ram_burst_master_if #(.DW(8), .AW(6), .LW(6)) bus ();

    ram_burst_master #(.DW(8), .AW(6), .LW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // RAM model with a backdoor write port for preloading.
    logic [7:0] mem [64];
    logic [5:0] addr_q;
    logic       bk_we;
    logic [5:0] bk_addr;
    logic [7:0] bk_data;

    always @(posedge clk) begin
        if (bk_we)
            mem[bk_addr] <= bk_data;
        else if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_data;
        if (!bus.ram_we)
            addr_q <= bus.ram_addr;
    end
    assign bus.ram_q = mem[addr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bk_we   = 1'b1;
            bk_addr = 6'(i);
            bk_data = 8'(i) ^ 8'h55;
        end
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    // Presents a command and returns 1 time unit after the accepting edge.
    task automatic send_cmd(input logic we, input logic [5:0] addr,
                            input logic [7:0] wdata, input logic [5:0] len);
        int n;
        @(negedge clk);
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (!bus.cmd_ready) begin
            $display("FAIL cmd_accept_timeout: cmd_ready got 0 required 1");
            bus.cmd_valid = 1'b0;
        end else begin
            pass_cnt++;
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({bus.cmd_ready, bus.ram_we, bus.rd_valid, bus.rd_last, bus.done} !== 5'b0)
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.cmd_ready, bus.ram_we, bus.rd_valid, bus.rd_last, bus.done});
        else pass_cnt++;
        total_cnt++;
        if ({bus.ram_addr, bus.ram_data, bus.rd_data} !== 22'h0)
            $display("FAIL reset_data: got %h required 0",
                     {bus.ram_addr, bus.ram_data, bus.rd_data});
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.cmd_ready !== 1'b0)
            $display("FAIL reset_release_same: cmd_ready got %b required 0", bus.cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.cmd_ready !== 1'b1)
            $display("FAIL reset_release_next: cmd_ready got %b required 1", bus.cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        send_cmd(1'b1, 6'd5, 8'hA5, 6'd0);
        @(negedge clk);
        total_cnt++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_data, bus.done} !== {1'b1, 6'd5, 8'hA5, 1'b0})
            $display("FAIL single_wr_beat: we/addr/data/done got %b/%0d/%h/%b required 1/5/a5/0",
                     bus.ram_we, bus.ram_addr, bus.ram_data, bus.done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({bus.ram_we, bus.done, bus.cmd_ready} !== 3'b011)
            $display("FAIL single_wr_done: we/done/ready got %b required 011",
                     {bus.ram_we, bus.done, bus.cmd_ready});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ((bus.done !== 1'b0) || (mem[5] !== 8'hA5))
            $display("FAIL single_wr_mem: done/mem5 got %b/%h required 0/a5", bus.done, mem[5]);
        else pass_cnt++;

        send_cmd(1'b0, 6'd5, 8'h00, 6'd0);
        @(negedge clk);
        total_cnt++;
        if ((bus.rd_valid !== 1'b0) || (bus.ram_we !== 1'b0) || (bus.ram_addr !== 6'd5))
            $display("FAIL single_rd_issue: valid/we/addr got %b/%b/%0d required 0/0/5",
                     bus.rd_valid, bus.ram_we, bus.ram_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({bus.rd_valid, bus.rd_data, bus.rd_last, bus.done} !== {1'b1, 8'hA5, 1'b1, 1'b1})
            $display("FAIL single_rd_data: valid/data/last/done got %b/%h/%b/%b required 1/a5/1/1",
                     bus.rd_valid, bus.rd_data, bus.rd_last, bus.done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({bus.rd_valid, bus.rd_last, bus.done} !== 3'b000)
            $display("FAIL single_rd_tail: got %b required 000",
                     {bus.rd_valid, bus.rd_last, bus.done});
        else pass_cnt++;
    endtask

    task automatic test_fill_wrap();
        logic [5:0]  wmask, vmask, lmask, dmask;
        logic [23:0] wseq;
        int          nw;
        logic        data_ok;
        wmask = '0; vmask = '0; lmask = '0; dmask = '0; wseq = '0; nw = 0;
        send_cmd(1'b1, 6'd62, 8'h3C, 6'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                wmask[i] = 1'b1;
                wseq = {wseq[17:0], bus.ram_addr};
                nw++;
            end
            dmask[i] = bus.done;
        end
        total_cnt++;
        if ((wmask !== 6'b001111) || (nw != 4) || (wseq !== {6'd62, 6'd63, 6'd0, 6'd1}))
            $display("FAIL fill_wrap_addrs: mask/seq got %b/%h required 001111/%h",
                     wmask, wseq, {6'd62, 6'd63, 6'd0, 6'd1});
        else pass_cnt++;
        total_cnt++;
        if (dmask !== 6'b010000)
            $display("FAIL fill_wrap_done: got %b required 010000", dmask);
        else pass_cnt++;
        total_cnt++;
        if ({mem[62], mem[63], mem[0], mem[1], mem[2], mem[61]} !==
            {8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h57, 8'h68})
            $display("FAIL fill_wrap_mem: got %h required 3c3c3c3c5768",
                     {mem[62], mem[63], mem[0], mem[1], mem[2], mem[61]});
        else pass_cnt++;

        dmask = '0; data_ok = 1'b1;
        send_cmd(1'b0, 6'd62, 8'h00, 6'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vmask[i] = bus.rd_valid;
            lmask[i] = bus.rd_last;
            dmask[i] = bus.done;
            if (bus.rd_valid && bus.rd_data !== 8'h3C) data_ok = 1'b0;
        end
        total_cnt++;
        if ((vmask !== 6'b011110) || !data_ok)
            $display("FAIL burst_rd_valid: mask/data_ok got %b/%b required 011110/1", vmask, data_ok);
        else pass_cnt++;
        total_cnt++;
        if ((lmask !== 6'b010000) || (dmask !== 6'b010000))
            $display("FAIL burst_rd_last: last/done got %b/%b required 010000/010000", lmask, dmask);
        else pass_cnt++;
    endtask

    task automatic test_full_clear();
        int first_we, last_we, n_we, done_at, n_done, n_vld, n_bad;
        first_we = -1; last_we = -1; n_we = 0; done_at = -1; n_done = 0;
        preload();
        total_cnt++;
        if ((mem[0] !== 8'h55) || (mem[63] !== 8'h6A))
            $display("FAIL clear_preload: mem0/mem63 got %h/%h required 55/6a", mem[0], mem[63]);
        else pass_cnt++;
        send_cmd(1'b1, 6'd0, 8'h00, 6'd63);
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                if (first_we < 0) first_we = i;
                last_we = i;
                n_we++;
            end
            if (bus.done) begin
                done_at = i;
                n_done++;
            end
        end
        total_cnt++;
        if ((n_we != 64) || (first_we != 0) || (last_we != 63))
            $display("FAIL clear_we_run: count/first/last got %0d/%0d/%0d required 64/0/63",
                     n_we, first_we, last_we);
        else pass_cnt++;
        total_cnt++;
        if ((n_done != 1) || (done_at != 64))
            $display("FAIL clear_done: count/at got %0d/%0d required 1/64", n_done, done_at);
        else pass_cnt++;

        n_vld = 0; n_bad = 0; n_done = 0;
        send_cmd(1'b0, 6'd0, 8'h00, 6'd63);
        for (int i = 0; i < 67; i++) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                n_vld++;
                if (bus.rd_data !== 8'h00) n_bad++;
            end
            if (bus.done) n_done++;
        end
        total_cnt++;
        if ((n_vld != 64) || (n_bad != 0) || (n_done != 1))
            $display("FAIL clear_readback: beats/bad/done got %0d/%0d/%0d required 64/0/1",
                     n_vld, n_bad, n_done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] vmask, lmask, dmask, wmask;
        int         acc_i;
        logic       data_ok, wr_ok;
        vmask = '0; lmask = '0; dmask = '0; wmask = '0;
        acc_i = -1; data_ok = 1'b1; wr_ok = 1'b1;
        send_cmd(1'b1, 6'd20, 8'h77, 6'd1);
        repeat (4) @(negedge clk);

        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 6'd20;
        bus.cmd_wdata = 8'h00;
        bus.cmd_len   = 6'd1;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_we    = 1'b1;
        bus.cmd_wdata = 8'h99;
        bus.cmd_len   = 6'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vmask[i] = bus.rd_valid;
            lmask[i] = bus.rd_last;
            dmask[i] = bus.done;
            wmask[i] = bus.ram_we;
            if (bus.rd_valid && bus.rd_data !== 8'h77) data_ok = 1'b0;
            if (bus.ram_we && ({bus.ram_addr, bus.ram_data} !== {6'd20, 8'h99})) wr_ok = 1'b0;
            if (bus.cmd_ready && bus.cmd_valid) begin
                acc_i = i;
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
            end
        end
        total_cnt++;
        if (acc_i != 2)
            $display("FAIL b2b_accept: sample got %0d required 2", acc_i);
        else pass_cnt++;
        total_cnt++;
        if ((vmask !== 7'b0000110) || (lmask !== 7'b0000100) || !data_ok)
            $display("FAIL b2b_read: valid/last/data_ok got %b/%b/%b required 0000110/0000100/1",
                     vmask, lmask, data_ok);
        else pass_cnt++;
        total_cnt++;
        if ((wmask !== 7'b0001000) || !wr_ok || (dmask !== 7'b0010100))
            $display("FAIL b2b_write: we/wr_ok/done got %b/%b/%b required 0001000/1/0010100",
                     wmask, wr_ok, dmask);
        else pass_cnt++;
        total_cnt++;
        if ({mem[20], mem[21]} !== {8'h99, 8'h77})
            $display("FAIL b2b_mem: got %h required 9977", {mem[20], mem[21]});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        int   n_done;
        logic unchanged;
        n_done = 0; unchanged = 1'b1;
        send_cmd(1'b1, 6'd10, 8'hE7, 6'd7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ((bus.ram_we !== 1'b1) || (bus.ram_addr !== 6'd12))
            $display("FAIL abort_third_beat: we/addr got %b/%0d required 1/12",
                     bus.ram_we, bus.ram_addr);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.ram_we, bus.rd_valid, bus.rd_last, bus.done, bus.cmd_ready} !== 5'b0)
            $display("FAIL abort_outputs: got %b required 00000",
                     {bus.ram_we, bus.rd_valid, bus.rd_last, bus.done, bus.cmd_ready});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        total_cnt++;
        if ((n_done != 0) || (bus.cmd_ready !== 1'b1))
            $display("FAIL abort_no_done: done count/ready got %0d/%b required 0/1",
                     n_done, bus.cmd_ready);
        else pass_cnt++;
        for (int a = 13; a <= 17; a++)
            if (mem[a] !== 8'h00) unchanged = 1'b0;
        total_cnt++;
        if (({mem[10], mem[11], mem[12]} !== {8'hE7, 8'hE7, 8'hE7}) || !unchanged)
            $display("FAIL abort_mem: mem10..12 %h unchanged13..17 %b required e7e7e7 1",
                     {mem[10], mem[11], mem[12]}, unchanged);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst           = 1'b1;
        bk_we         = 1'b0;
        bk_addr       = '0;
        bk_data       = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_len   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        preload();
        test_single();
        test_fill_wrap();
        test_full_clear();
        test_back_to_back();
        test_reset_mid_burst();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
